// File: rtl/crc8_framer_pkg.sv
// Shared definitions for the CRC-8 framer: state encoding, polynomial, CRC step.
package crc8_framer_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [7:0]  CRC_POLY = 8'h07;

  typedef enum logic {
    DATA = 1'b0,
    CRC  = 1'b1
  } framer_state_t;

  // One byte of MSB-first CRC-8, no reflection, no final XOR.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc,
                                             input logic [7:0] data,
                                             input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_framer_if.sv
// Byte stream handshake between source, framer and sink.
interface crc8_framer_if;
  import crc8_framer_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  // Framer side
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  // Source/sink side
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/crc8_framer_calc.sv
// Running CRC-8 register: folds in a byte on calculate, returns to zero on clear.
module crc8_calculator
  import crc8_framer_pkg::*;
#(
  parameter logic [7:0] POLY = CRC_POLY
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_calc,
  input  logic       i_clear,
  input  logic [7:0] i_data,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;

  // CRC accumulator; reset and clear both restart from the zero init value
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_crc <= 8'h00;
    end else if (i_calc) begin
      r_crc <= crc8_update(r_crc, i_data, POLY);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/crc8_framer.sv
// Passes payload bytes through unchanged and appends one CRC-8 byte per frame.
module crc8_framer
  import crc8_framer_pkg::*;
#(
  parameter int unsigned MAX_LEN = 64
) (
  input  logic              clock,
  input  logic              reset,
  crc8_framer_if.slave      bus,
  output logic              overflow,
  output logic [7:0]        frame_count
);

  localparam logic [7:0] LAST_IDX = 8'(MAX_LEN - 1);

  framer_state_t r_state;
  logic [7:0]    r_byte_cnt;
  logic [7:0]    r_frame_count;
  logic          r_overflow;

  logic          w_in_hs;
  logic          w_crc_hs;
  logic          w_at_max;
  logic [7:0]    w_crc;

  assign w_in_hs  = (r_state == DATA) && bus.in_valid && bus.out_ready;
  assign w_crc_hs = (r_state == CRC) && bus.out_ready;
  assign w_at_max = (r_byte_cnt == LAST_IDX);

  // calculate and clear come from different states, so never coincide
  crc8_calculator u_crc (
    .clock   (clock),
    .reset   (reset),
    .i_calc  (w_in_hs),
    .i_clear (w_crc_hs),
    .i_data  (bus.in_data),
    .o_crc   (w_crc)
  );

  // Output mux: zero-latency pass-through in DATA, held CRC byte in CRC
  always_comb begin
    bus.out_data  = bus.in_data;
    bus.out_valid = bus.in_valid;
    bus.out_last  = 1'b0;
    bus.in_ready  = bus.out_ready;
    if (r_state == CRC) begin
      bus.out_data  = w_crc;
      bus.out_valid = 1'b1;
      bus.out_last  = 1'b1;
      bus.in_ready  = 1'b0;
    end
  end

  // Frame state, byte counter, frame counter and sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= DATA;
      r_byte_cnt    <= 8'd0;
      r_frame_count <= 8'd0;
      r_overflow    <= 1'b0;
    end else begin
      case (r_state)
        DATA: begin
          if (w_in_hs) begin
            r_byte_cnt <= r_byte_cnt + 8'd1;
            if (bus.in_last || w_at_max) begin
              r_state <= CRC;
            end
            if (!bus.in_last && w_at_max) begin
              r_overflow <= 1'b1;
            end
          end
        end
        CRC: begin
          if (bus.out_ready) begin
            r_byte_cnt    <= 8'd0;
            r_frame_count <= r_frame_count + 8'd1;
            r_state       <= DATA;
          end
        end
        default: r_state <= DATA;
      endcase
    end
  end

  assign overflow    = r_overflow;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_crc8_framer.sv
// Scoreboard bench for crc8_framer: one instance at MAX_LEN=64, one at MAX_LEN=4.
module tb_crc8_framer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       sel;
  logic [7:0] drv_data;
  logic       drv_valid;
  logic       drv_last;
  logic       drv_ready;

  crc8_framer_if if_a ();
  crc8_framer_if if_b ();

  logic       ovf_a, ovf_b;
  logic [7:0] fc_a, fc_b;

  crc8_framer #(.MAX_LEN(64)) u_dut_a (
    .clock       (clock),
    .reset       (reset),
    .bus         (if_a.slave),
    .overflow    (ovf_a),
    .frame_count (fc_a)
  );

  crc8_framer #(.MAX_LEN(4)) u_dut_b (
    .clock       (clock),
    .reset       (reset),
    .bus         (if_b.slave),
    .overflow    (ovf_b),
    .frame_count (fc_b)
  );

  // Drive the selected instance; the other sees no valid and no ready
  assign if_a.in_data   = drv_data;
  assign if_a.in_valid  = drv_valid & ~sel;
  assign if_a.in_last   = drv_last;
  assign if_a.out_ready = drv_ready & ~sel;
  assign if_b.in_data   = drv_data;
  assign if_b.in_valid  = drv_valid & sel;
  assign if_b.in_last   = drv_last;
  assign if_b.out_ready = drv_ready & sel;

  wire [7:0] obs_data     = sel ? if_b.out_data  : if_a.out_data;
  wire       obs_valid    = sel ? if_b.out_valid : if_a.out_valid;
  wire       obs_last     = sel ? if_b.out_last  : if_a.out_last;
  wire       obs_in_ready = sel ? if_b.in_ready  : if_a.in_ready;
  wire       obs_ovf      = sel ? ovf_b : ovf_a;
  wire [7:0] obs_fc       = sel ? fc_b  : fc_a;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: serial LFSR form of CRC-8 poly 0x07
  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] m_crc;
  int         m_cnt;
  int         m_max;
  logic       m_ovf;
  int         m_frames;

  task automatic model_reset();
    sb.delete();
    m_crc    = 8'h00;
    m_cnt    = 0;
    m_ovf    = 1'b0;
    m_frames = 0;
  endtask

  task automatic model_push(input logic [7:0] b, input logic last);
    sb.push_back('{data: b, last: 1'b0});
    m_crc = ref_crc(m_crc, b);
    m_cnt++;
    if (last || m_cnt == m_max) begin
      if (!last) m_ovf = 1'b1;
      sb.push_back('{data: m_crc, last: 1'b1});
      m_crc    = 8'h00;
      m_cnt    = 0;
      m_frames = (m_frames + 1) % 256;
    end
  endtask

  // Monitor: a beat transfers on the next edge when valid and ready are both high
  always @(negedge clock) begin
    if (!reset && obs_valid && drv_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_beat", {7'd0, obs_valid}, 8'd0);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check_eq("out_data", obs_data, e.data);
        check_eq("out_last", {7'd0, obs_last}, {7'd0, e.last});
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic last);
    bit acc;
    acc       = 1'b0;
    drv_data  = b;
    drv_last  = last;
    drv_valid = 1'b1;
    model_push(b, last);
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clock);
      acc = obs_in_ready;
      @(posedge clock);
      #1;
    end
    if (!acc) check_eq("accept_timeout", {7'd0, acc}, 8'd1);
    drv_valid    = 1'b0;
    drv_last     = 1'b0;
    last_acc_cyc = cyc;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clock);
    @(posedge clock);
    #1;
    check_eq("drain", 8'(sb.size()), 8'd0);
  endtask

  task automatic do_reset();
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    drv_ready = 1'b1;
    reset     = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int c9;
    sel       = 1'b0;
    drv_data  = 8'h00;
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    drv_ready = 1'b1;
    m_max     = 64;
    reset     = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Reset state and DATA pass-through while reset is held
    check_eq("rst_out_valid", {7'd0, obs_valid}, 8'd0);
    check_eq("rst_out_last",  {7'd0, obs_last}, 8'd0);
    check_eq("rst_in_ready",  {7'd0, obs_in_ready}, 8'd1);
    check_eq("rst_overflow",  {7'd0, obs_ovf}, 8'd0);
    check_eq("rst_frame_cnt", obs_fc, 8'd0);
    drv_valid = 1'b1;
    drv_data  = 8'h5A;
    drv_ready = 1'b0;
    #1;
    check_eq("rst_pass_data",  obs_data, 8'h5A);
    check_eq("rst_pass_valid", {7'd0, obs_valid}, 8'd1);
    check_eq("rst_ready_low",  {7'd0, obs_in_ready}, 8'd0);
    do_reset();

    // Single byte frame
    send(8'h01, 1'b1);
    drain();
    check_eq("fc_single", obs_fc, 8'(m_frames));
    check_eq("fc_single_abs", obs_fc, 8'd1);

    // Two byte frame
    send(8'h01, 1'b0);
    send(8'h02, 1'b1);
    drain();
    check_eq("fc_two", obs_fc, 8'd2);

    // Check string followed immediately by a one-byte frame
    for (int i = 1; i <= 9; i++) send(8'(8'h30 + i), i == 9);
    c9 = last_acc_cyc;
    send(8'h00, 1'b1);
    check_eq("zero_bubble", 8'(last_acc_cyc - c9), 8'd2);
    drain();
    check_eq("fc_check", obs_fc, 8'd4);

    // Downstream stall while the CRC byte is presented
    for (int i = 1; i <= 9; i++) send(8'(8'h30 + i), i == 9);
    drv_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("stall_data",     obs_data, 8'hF4);
      check_eq("stall_valid",    {7'd0, obs_valid}, 8'd1);
      check_eq("stall_last",     {7'd0, obs_last}, 8'd1);
      check_eq("stall_in_ready", {7'd0, obs_in_ready}, 8'd0);
    end
    @(posedge clock);
    #1;
    drv_ready = 1'b1;
    drain();
    check_eq("fc_stall", obs_fc, 8'd5);
    check_eq("ovf_a_none", {7'd0, obs_ovf}, 8'd0);

    // Reset mid-frame abandons it
    send(8'h0A, 1'b0);
    send(8'h0B, 1'b0);
    do_reset();
    check_eq("fc_after_rst", obs_fc, 8'd0);
    send(8'h01, 1'b1);
    drain();
    check_eq("fc_after_rst_frame", obs_fc, 8'd1);

    // MAX_LEN=4 instance: truncation and overflow
    sel   = 1'b1;
    m_max = 4;
    do_reset();
    check_eq("b_ovf_reset", {7'd0, obs_ovf}, 8'd0);
    for (int i = 1; i <= 5; i++) send(8'(8'h10 * i + i), 1'b0);
    send(8'h66, 1'b1);
    drain();
    check_eq("b_overflow", {7'd0, obs_ovf}, {7'd0, m_ovf});
    check_eq("b_overflow_abs", {7'd0, obs_ovf}, 8'd1);
    check_eq("b_frame_cnt", obs_fc, 8'd2);
    check_eq("a_ovf_clear", {7'd0, ovf_a}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
